// File: rtl/alu_with_register_file.sv
// alu_with_register_file
//   8-bit ALU with a 16 x 8-bit register file, one 26-bit instruction per clock.
//   instruction = {op[25:22], rd[21:18], rs1[17:14], rs2[13:10], imm8[9:2], rsvd[1:0]}
//   Operand reads are combinational. Result, flags and the rd write all land on the same rising edge.
//   R0 is hard-wired to zero.
//   Optional feature macro: ALU_MUL_EN.
//     When defined, opcode 3 is an unsigned 8x8 multiply.
//     When undefined, opcode 3 is a NOP and no multiplier is built.
module alu_with_register_file (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] instruction,
  output logic [15:0] out,
  output logic        overflow,
  output logic        c_out
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_ADD  = 4'd1,  OP_SUB  = 4'd2,  OP_MUL  = 4'd3,
    OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_NOT  = 4'd7,
    OP_SHL  = 4'd8,  OP_SHR  = 4'd9,  OP_ADDI = 4'd10, OP_SUBI = 4'd11,
    OP_CMP  = 4'd12, OP_LDI  = 4'd13, OP_MOV  = 4'd14, OP_PASS = 4'd15
  } op_e;

  op_e        op;
  logic [3:0] rd, rs1, rs2;
  logic [7:0] imm;
  logic       unused_rsvd;

  assign op          = op_e'(instruction[25:22]);
  assign rd          = instruction[21:18];
  assign rs1         = instruction[17:14];
  assign rs2         = instruction[13:10];
  assign imm         = instruction[9:2];
  assign unused_rsvd = ^instruction[1:0];

  // Register file: R0 is a constant, R1..R15 are flops so every word can be cleared by reset
  logic [7:0] rf_data [16];
  logic       wr_en;
  logic [7:0] wr_data;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf_data[gi] = 8'h00;
      end else begin : g_word
        logic [7:0] word_reg;
        // Clear on reset; otherwise capture the ALU result when this word is the destination
        always_ff @(posedge clock) begin
          if (reset) begin
            word_reg <= 8'h00;
          end else if (wr_en && (rd == 4'(gi))) begin
            word_reg <= wr_data;
          end
        end
        assign rf_data[gi] = word_reg;
      end
    end
  endgenerate

  // Operands: old register contents are used even when rd matches a source
  logic [7:0] a, b, op_b;
  logic [8:0] sum9, diff9;
  logic       add_ovf, sub_ovf;
  logic [2:0] sh;
  logic [7:0] shl_res, shr_res;
  logic       shl_c, shr_c;

  assign a       = rf_data[rs1];
  assign b       = rf_data[rs2];
  assign op_b    = ((op == OP_ADDI) || (op == OP_SUBI)) ? imm : b;
  assign sum9    = {1'b0, a} + {1'b0, op_b};
  assign diff9   = {1'b0, a} - {1'b0, op_b};
  assign add_ovf = (a[7] == op_b[7]) && (sum9[7] != a[7]);
  assign sub_ovf = (a[7] != op_b[7]) && (diff9[7] != a[7]);
  assign sh      = b[2:0];
  assign shl_res = a << sh;
  assign shr_res = a >> sh;
  // Last bit shifted out: bit (8-sh) for a left shift, bit (sh-1) for a right shift
  assign shl_c   = (sh == 3'd0) ? 1'b0 : a[3'd0 - sh];
  assign shr_c   = (sh == 3'd0) ? 1'b0 : a[sh - 3'd1];

`ifdef ALU_MUL_EN
  logic [15:0] prod;
  assign prod = a * b;
`endif

  logic [15:0] out_reg, out_next;
  logic        overflow_reg, overflow_next;
  logic        c_out_reg, c_out_next;
  logic        upd;

  // Decode: select result and flags, decide whether out/flags update and whether rd is written
  always_comb begin
    out_next      = out_reg;
    overflow_next = 1'b0;
    c_out_next    = 1'b0;
    upd           = 1'b1;
    wr_en         = 1'b1;
    case (op)
      OP_ADD, OP_ADDI: begin
        out_next      = {8'h00, sum9[7:0]};
        c_out_next    = sum9[8];
        overflow_next = add_ovf;
      end
      OP_SUB, OP_SUBI, OP_CMP: begin
        out_next      = {8'h00, diff9[7:0]};
        c_out_next    = diff9[8];
        overflow_next = sub_ovf;
        wr_en         = (op != OP_CMP);
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        out_next      = prod;
        overflow_next = |prod[15:8];
      end
`endif
      OP_AND:  out_next = {8'h00, a & b};
      OP_OR:   out_next = {8'h00, a | b};
      OP_XOR:  out_next = {8'h00, a ^ b};
      OP_NOT:  out_next = {8'h00, ~a};
      OP_SHL: begin
        out_next   = {8'h00, shl_res};
        c_out_next = shl_c;
      end
      OP_SHR: begin
        out_next   = {8'h00, shr_res};
        c_out_next = shr_c;
      end
      OP_LDI:  out_next = {8'h00, imm};
      OP_MOV:  out_next = {8'h00, a};
      OP_PASS: begin
        out_next = {8'h00, a};
        wr_en    = 1'b0;
      end
      default: begin
        // NOP, and MUL when the multiplier is not built: hold everything
        upd   = 1'b0;
        wr_en = 1'b0;
      end
    endcase
    if (!upd) begin
      overflow_next = overflow_reg;
      c_out_next    = c_out_reg;
    end
  end

  assign wr_data = out_next[7:0];

  // Output and flag registers; reset wins over any instruction on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      out_reg      <= 16'h0000;
      overflow_reg <= 1'b0;
      c_out_reg    <= 1'b0;
    end else if (upd) begin
      out_reg      <= out_next;
      overflow_reg <= overflow_next;
      c_out_reg    <= c_out_next;
    end
  end

  assign out      = out_reg;
  assign overflow = overflow_reg;
  assign c_out    = c_out_reg;

endmodule

// File: tb/tb_alu_with_register_file.sv
// tb_alu_with_register_file: directed vectors with hand-computed results for alu_with_register_file.
// Honours ALU_MUL_EN the same way as the design (MUL vs NOP expectations).
module tb_alu_with_register_file;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [25:0] instruction = '0;
  logic [15:0] out;
  logic        overflow;
  logic        c_out;

  int checks = 0;
  int errors = 0;

  alu_with_register_file dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .out         (out),
    .overflow    (overflow),
    .c_out       (c_out)
  );

  always #5 clock = ~clock;

  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, MUL = 4'd3, AND_ = 4'd4,
                         OR_ = 4'd5, XOR_ = 4'd6, NOT_ = 4'd7, SHL = 4'd8, SHR = 4'd9,
                         ADDI = 4'd10, SUBI = 4'd11, CMP = 4'd12, LDI = 4'd13, MOV = 4'd14,
                         PASS = 4'd15;

  function automatic logic [25:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [7:0] imm);
    return {op, rd, rs1, rs2, imm, 2'b00};
  endfunction

  // Apply one instruction for one rising edge, then settle #1 past the edge
  task automatic run(input logic [25:0] i, input logic rst = 1'b0);
    @(negedge clock);
    instruction = i;
    reset = rst;
    @(posedge clock);
    #1;
    reset = 1'b0;
    $display("instr=%07h reset=%0b -> out=%04h overflow=%0b c_out=%0b", i, rst, out, overflow, c_out);
  endtask

  task automatic test_reset();
    run(ins(LDI, 4'd5, 4'd0, 4'd0, 8'h77), 1'b1);
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got %04h want 0000", out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c got %0b want 0", c_out); end
    run(ins(PASS, 4'd0, 4'd5, 4'd0, 8'h00));
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_pass_r5 got %04h want 0000", out); end
  endtask

  task automatic test_add();
    run(26'h36E3200);
    checks++; if (out !== 16'h0080) begin errors++; $display("FAIL ldi_raw got %04h want 0080", out); end
    run(ins(LDI, 4'd12, 4'd0, 4'd0, 8'h80));
    run(ins(ADD, 4'd1, 4'd11, 4'd12, 8'h00));
    checks++; if (out !== 16'h0000 || c_out !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL add_80_80 got out=%04h c=%0b v=%0b want 0000 1 1", out, c_out, overflow); end
    run(ins(LDI, 4'd13, 4'd0, 4'd0, 8'h7F));
    run(ins(ADD, 4'd14, 4'd13, 4'd13, 8'h00));
    checks++; if (out !== 16'h00FE || c_out !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL add_7f_7f got out=%04h c=%0b v=%0b want 00fe 0 1", out, c_out, overflow); end
    run(ins(ADDI, 4'd15, 4'd13, 4'd0, 8'h01));
    checks++; if (out !== 16'h0080 || c_out !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL addi got out=%04h c=%0b v=%0b want 0080 0 1", out, c_out, overflow); end
    // rsvd bits set: must be ignored
    run(ins(PASS, 4'd0, 4'd14, 4'd0, 8'h00) | 26'h3);
    checks++; if (out !== 16'h00FE) begin errors++; $display("FAIL pass_r14_rsvd got %04h want 00fe", out); end
  endtask

  task automatic test_mul();
    run(ins(LDI, 4'd4, 4'd0, 4'd0, 8'h33));
    run(ins(LDI, 4'd2, 4'd0, 4'd0, 8'h10));
    run(ins(LDI, 4'd3, 4'd0, 4'd0, 8'h20));
    run(ins(MUL, 4'd4, 4'd2, 4'd3, 8'h00));
`ifdef ALU_MUL_EN
    checks++; if (out !== 16'h0200 || overflow !== 1'b1 || c_out !== 1'b0) begin
      errors++; $display("FAIL mul got out=%04h v=%0b c=%0b want 0200 1 0", out, overflow, c_out); end
    run(ins(PASS, 4'd0, 4'd4, 4'd0, 8'h00));
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL mul_r4 got %04h want 0000", out); end
`else
    checks++; if (out !== 16'h0020 || overflow !== 1'b0 || c_out !== 1'b0) begin
      errors++; $display("FAIL mul_as_nop got out=%04h v=%0b c=%0b want 0020 0 0", out, overflow, c_out); end
    run(ins(PASS, 4'd0, 4'd4, 4'd0, 8'h00));
    checks++; if (out !== 16'h0033) begin errors++; $display("FAIL mul_as_nop_r4 got %04h want 0033", out); end
`endif
  endtask

  task automatic test_sub_cmp();
    run(ins(SUB, 4'd5, 4'd2, 4'd3, 8'h00));
    checks++; if (out !== 16'h00F0 || c_out !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL sub got out=%04h c=%0b v=%0b want 00f0 1 0", out, c_out, overflow); end
    run(ins(CMP, 4'd2, 4'd2, 4'd2, 8'h00));
    checks++; if (out !== 16'h0000 || c_out !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL cmp got out=%04h c=%0b v=%0b want 0000 0 0", out, c_out, overflow); end
    run(ins(PASS, 4'd0, 4'd2, 4'd0, 8'h00));
    checks++; if (out !== 16'h0010) begin errors++; $display("FAIL cmp_nowrite got %04h want 0010", out); end
    run(ins(PASS, 4'd0, 4'd5, 4'd0, 8'h00));
    checks++; if (out !== 16'h00F0) begin errors++; $display("FAIL sub_r5 got %04h want 00f0", out); end
    run(ins(LDI, 4'd7, 4'd0, 4'd0, 8'h80));
    run(ins(SUBI, 4'd9, 4'd7, 4'd0, 8'h01));
    checks++; if (out !== 16'h007F || c_out !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL subi got out=%04h c=%0b v=%0b want 007f 0 1", out, c_out, overflow); end
  endtask

  task automatic test_r0();
    run(ins(LDI, 4'd0, 4'd0, 4'd0, 8'h55));
    checks++; if (out !== 16'h0055) begin errors++; $display("FAIL ldi_r0_out got %04h want 0055", out); end
    run(ins(PASS, 4'd0, 4'd0, 4'd0, 8'h00));
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL r0_zero got %04h want 0000", out); end
  endtask

  task automatic test_logic();
    run(ins(LDI, 4'd10, 4'd0, 4'd0, 8'hCC));
    run(ins(LDI, 4'd11, 4'd0, 4'd0, 8'hAA));
    run(ins(AND_, 4'd12, 4'd10, 4'd11, 8'h00));
    checks++; if (out !== 16'h0088) begin errors++; $display("FAIL and got %04h want 0088", out); end
    run(ins(OR_, 4'd12, 4'd10, 4'd11, 8'h00));
    checks++; if (out !== 16'h00EE) begin errors++; $display("FAIL or got %04h want 00ee", out); end
    run(ins(XOR_, 4'd12, 4'd10, 4'd11, 8'h00));
    checks++; if (out !== 16'h0066) begin errors++; $display("FAIL xor got %04h want 0066", out); end
    run(ins(NOT_, 4'd12, 4'd10, 4'd0, 8'h00));
    checks++; if (out !== 16'h0033) begin errors++; $display("FAIL not got %04h want 0033", out); end
    run(ins(MOV, 4'd13, 4'd10, 4'd0, 8'h00));
    checks++; if (out !== 16'h00CC) begin errors++; $display("FAIL mov got %04h want 00cc", out); end
    run(ins(NOP, 4'd13, 4'd11, 4'd11, 8'h12));
    checks++; if (out !== 16'h00CC) begin errors++; $display("FAIL nop_hold got %04h want 00cc", out); end
    run(ins(PASS, 4'd0, 4'd13, 4'd0, 8'h00));
    checks++; if (out !== 16'h00CC) begin errors++; $display("FAIL nop_nowrite got %04h want 00cc", out); end
  endtask

  task automatic test_back_to_back();
    // rd == rs1: old value used, new value visible on the very next instruction
    run(ins(ADD, 4'd10, 4'd10, 4'd11, 8'h00));
    checks++; if (out !== 16'h0076 || c_out !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL add_self got out=%04h c=%0b v=%0b want 0076 1 1", out, c_out, overflow); end
    run(ins(AND_, 4'd12, 4'd10, 4'd10, 8'h00));
    checks++; if (out !== 16'h0076 || c_out !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_read got out=%04h c=%0b v=%0b want 0076 0 0", out, c_out, overflow); end
  endtask

  task automatic test_shift_reset();
    run(ins(LDI, 4'd6, 4'd0, 4'd0, 8'h81));
    run(ins(LDI, 4'd7, 4'd0, 4'd0, 8'h01));
    run(ins(SHL, 4'd8, 4'd6, 4'd7, 8'h00));
    checks++; if (out !== 16'h0002 || c_out !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL shl1 got out=%04h c=%0b v=%0b want 0002 1 0", out, c_out, overflow); end
    run(ins(SHR, 4'd9, 4'd6, 4'd7, 8'h00));
    checks++; if (out !== 16'h0040 || c_out !== 1'b1) begin
      errors++; $display("FAIL shr1 got out=%04h c=%0b want 0040 1", out, c_out); end
    run(ins(LDI, 4'd7, 4'd0, 4'd0, 8'h00));
    run(ins(SHL, 4'd8, 4'd6, 4'd7, 8'h00));
    checks++; if (out !== 16'h0081 || c_out !== 1'b0) begin
      errors++; $display("FAIL shl0 got out=%04h c=%0b want 0081 0", out, c_out); end
    run(ins(LDI, 4'd7, 4'd0, 4'd0, 8'h0A)); // only B[2:0]=2 matters
    run(ins(SHR, 4'd9, 4'd6, 4'd7, 8'h00));
    checks++; if (out !== 16'h0020 || c_out !== 1'b0) begin
      errors++; $display("FAIL shr2 got out=%04h c=%0b want 0020 0", out, c_out); end
    run(ins(SHL, 4'd9, 4'd6, 4'd7, 8'h00));
    checks++; if (out !== 16'h0004 || c_out !== 1'b0) begin
      errors++; $display("FAIL shl2 got out=%04h c=%0b want 0004 0", out, c_out); end
    run(ins(ADD, 4'd1, 4'd6, 4'd6, 8'h00));
    checks++; if (c_out !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL pre_reset_flags got c=%0b v=%0b want 1 1", c_out, overflow); end
    run(ins(LDI, 4'd5, 4'd0, 4'd0, 8'hAA), 1'b1);
    checks++; if (out !== 16'h0000 || c_out !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset got out=%04h c=%0b v=%0b want 0000 0 0", out, c_out, overflow); end
    run(ins(PASS, 4'd0, 4'd6, 4'd0, 8'h00));
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_r6 got %04h want 0000", out); end
    run(ins(PASS, 4'd0, 4'd5, 4'd0, 8'h00));
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_r5 got %04h want 0000", out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_sub_cmp();
    test_r0();
    test_logic();
    test_back_to_back();
    test_shift_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
